sequence_transmitter: RTL

SEQUENCE_TRANSMITTER -- requirements
Module: sequence_transmitter

---
 rtl/sequence_transmitter.sv | 106 ++++++++++
 1 files changed

// File: rtl/sequence_transmitter.sv
// Serialises a WIDTH-bit frame LSB first, optionally repeating it back to back.
// Supports abort, a one-cycle done pulse and acceptance of a new request in the done cycle.
module sequence_transmitter #(
  parameter int unsigned WIDTH    = 7,
  parameter logic        IDLE_BIT = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inValid,
  output logic             inReady,
  input  logic [WIDTH-1:0] inData,
  input  logic [3:0]       repeatCount,
  input  logic             abort,
  output logic             dataOut,
  output logic             busy,
  output logic             done
);

  localparam int unsigned IdxW = $clog2(WIDTH);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(WIDTH - 1);

  typedef enum logic {StIdle, StShift} state_e;

  state_e           state_q, state_d;
  logic [IdxW-1:0]  idx_q, idx_d, idx_inc;
  logic [3:0]       rep_q, rep_d;
  logic [WIDTH-1:0] frame_q, frame_d;
  logic             data_q, data_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  assign inReady = (state_q == StIdle) && !abort && !reset;
  assign idx_inc = idx_q + 1'b1;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    rep_d   = rep_q;
    frame_d = frame_q;
    data_d  = data_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (inValid && inReady) begin
          state_d = StShift;
          frame_d = inData;
          data_d  = inData[0];
          busy_d  = 1'b1;
          idx_d   = '0;
          rep_d   = repeatCount;
        end
      end
      StShift: begin
        if (abort) begin
          state_d = StIdle;
          data_d  = IDLE_BIT;
          busy_d  = 1'b0;
          idx_d   = '0;
          rep_d   = '0;
        end else if (idx_q == LastIdx) begin
          idx_d = '0;
          if (rep_q != 4'd0) begin
            // Next repetition starts immediately, no gap bit.
            rep_d  = rep_q - 4'd1;
            data_d = frame_q[0];
          end else begin
            state_d = StIdle;
            data_d  = IDLE_BIT;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end else begin
          idx_d  = idx_inc;
          data_d = frame_q[idx_inc];
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      idx_q   <= '0;
      rep_q   <= '0;
      frame_q <= '0;
      data_q  <= IDLE_BIT;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rep_q   <= rep_d;
      frame_q <= frame_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign dataOut = data_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule
